// File: rtl/histogram_reduce_multi.sv
// histogram_reduce_multi
// Reads NUM_HIST histogram memories in lockstep, sums each bin and writes the
// result to one output memory at one bin per cycle. The block uses the
// ap_start/ap_done/ap_continue/ap_idle/ap_ready handshake.
// Optional macro HIST_REDUCE_SAT_EN: when defined, an overflowing bin sum is
// written as 2^DATA_W-1 (saturate); otherwise it is written modulo 2^DATA_W.
// The sticky ovf flag behaves the same way in both builds.
module histogram_reduce_multi #(
    parameter int NUM_HIST = 2,
    parameter int NUM_BINS = 256,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         ap_start,
    input  logic                         ap_continue,
    output logic                         ap_done,
    output logic                         ap_idle,
    output logic                         ap_ready,
    output logic [NUM_HIST*ADDR_W-1:0]   hist_address0,
    output logic [NUM_HIST-1:0]          hist_ce0,
    input  logic [NUM_HIST*DATA_W-1:0]   hist_q0,
    output logic [ADDR_W-1:0]            output_r_address0,
    output logic                         output_r_ce0,
    output logic                         output_r_we0,
    output logic [DATA_W-1:0]            output_r_d0,
    output logic                         ovf
);

    // The adder tree grows by clog2(NUM_HIST) bits so the full sum is kept.
    localparam int SUM_W = DATA_W + $clog2(NUM_HIST);
    // One extra counter bit so NUM_BINS = 2^ADDR_W does not wrap early.
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(NUM_BINS - 1);

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              drain_r;
    logic              rd_vld_r;
    logic              rd_last_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              wr_vld_r;
    logic              wr_last_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              done_reg_r;
    logic              ovf_r;

    logic [SUM_W-1:0]  sum_s;
    logic              sum_ovf_s;
    logic [DATA_W-1:0] bin_val_s;
    logic              accept_s;
    logic              run_s;
    logic              issue_last_s;
    logic              done_pulse_s;

    // A start is only taken in IDLE once the previous done was acknowledged.
    assign accept_s     = (state_r == S_IDLE) && ap_start && !done_reg_r;
    assign run_s        = (state_r == S_RUN);
    assign issue_last_s = run_s && (cnt_r == LAST_BIN);
    assign done_pulse_s = wr_vld_r && wr_last_r;

    // Sum all histogram slices at full width and derive the written value.
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        for (int h = 0; h < NUM_HIST; h++) begin
            sum_s = sum_s + SUM_W'(hist_q0[h*DATA_W +: DATA_W]);
        end
        sum_ovf_s = |sum_s[SUM_W-1:DATA_W];
`ifdef HIST_REDUCE_SAT_EN
        bin_val_s = sum_ovf_s ? {DATA_W{1'b1}} : sum_s[DATA_W-1:0];
`else
        bin_val_s = sum_s[DATA_W-1:0];
`endif
    end

    // Control FSM: IDLE -> RUN (one read per cycle) -> DRAIN (2 cycles) -> IDLE.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            drain_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        state_r <= S_RUN;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                S_RUN: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_BIN) begin
                        state_r <= S_DRAIN;
                        drain_r <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (drain_r) begin
                        state_r <= S_IDLE;
                    end else begin
                        drain_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Read-data and write stages; the bin address travels with its data.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rd_vld_r  <= 1'b0;
            rd_last_r <= 1'b0;
            rd_addr_r <= {ADDR_W{1'b0}};
            wr_vld_r  <= 1'b0;
            wr_last_r <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
        end else begin
            rd_vld_r  <= run_s;
            rd_last_r <= issue_last_s;
            wr_vld_r  <= rd_vld_r;
            wr_last_r <= rd_vld_r && rd_last_r;
            if (run_s) begin
                rd_addr_r <= cnt_r[ADDR_W-1:0];
            end
            if (rd_vld_r) begin
                wr_addr_r <= rd_addr_r;
                wr_data_r <= bin_val_s;
            end
        end
    end

    // Sticky overflow (cleared by an accepted start) and held done flag.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ovf_r      <= 1'b0;
            done_reg_r <= 1'b0;
        end else begin
            if (accept_s) begin
                ovf_r <= 1'b0;
            end else if (rd_vld_r && sum_ovf_s) begin
                ovf_r <= 1'b1;
            end
            if (ap_continue) begin
                done_reg_r <= 1'b0;
            end else if (done_pulse_s) begin
                done_reg_r <= 1'b1;
            end
        end
    end

    assign hist_address0     = {NUM_HIST{cnt_r[ADDR_W-1:0]}};
    assign hist_ce0          = {NUM_HIST{run_s}};
    assign output_r_address0 = wr_addr_r;
    assign output_r_ce0      = wr_vld_r;
    assign output_r_we0      = wr_vld_r;
    assign output_r_d0       = wr_data_r;
    // Overflow is visible in the cycle the offending sum is formed.
    assign ovf               = ovf_r || (rd_vld_r && sum_ovf_s);
    assign ap_done           = done_pulse_s || done_reg_r;
    assign ap_ready          = done_pulse_s;
    assign ap_idle           = (state_r == S_IDLE) && !ap_start && !done_reg_r;

endmodule
